aes_enc_ctrl: RTL and testbench
===============================

# aes_enc_ctrl

Sequencing controller for the iterative AES-128 encryption round datapath. It accepts one encryption request through a valid/ready handshake and steps the datapath through the initial key-addition round, the full rounds and the final round. For every round it drives the pipeline enable and the round-select controls (`full_enc`, `zero_rnd`, `final_rnd`). It also supplies the round index and the key-schedule round constant, and holds the finished ciphertext until a done handshake completes.

## Interface
Parameters:
- `NR`, 10: number of cipher rounds after round 0. Rounds run 0..NR.
- `ROUND_LAT`, 3: clock cycles one round spends in the datapath loop (S-box stage, shift-rows/mix-columns pipe, add-key pipe). Legal range 1..15.

Ports:
- `clk`, in, 1: the block's only clock.
- `nrst`, in, 1: asynchronous, active-low reset.
- `req_valid_i`, in, 1: new encryption request. Plaintext and key are stable on the datapath inputs while this is high.
- `req_ready_o`, out, 1: the controller can accept a request.
- `done_valid_o`, out, 1: ciphertext is valid at the datapath output.
- `done_ready_i`, in, 1: the consumer takes the ciphertext.
- `flush_i`, in, 1: synchronous abort.
- `en_o`, out, 1: datapath pipeline enable.
- `full_enc_o`, out, 1: select plaintext into the round input.
- `zero_rnd_o`, out, 1: select the cipher key instead of the round key.
- `final_rnd_o`, out, 1: bypass mix-columns.
- `rnd_idx_o`, out, 4: current round number, 0..NR.
- `rcon_o`, out, 8: AES round constant for `rnd_idx_o`.
- `busy_o`, out, 1: a request is in progress (RUN or DONE state).

## Operation
- FSM states: IDLE, RUN, DONE. Internal registers: `rnd` (4 bit), `cyc` (4 bit), `rcon` (8 bit).
- IDLE:
  - `req_ready_o=1`, `en_o=0`.
  - When `req_valid_i & req_ready_o`: go to RUN with `rnd=0`, `cyc=0`, `rcon=8'h00`.
- RUN:
  - `en_o=1`.
  - `cyc` increments each cycle. When `cyc==ROUND_LAT-1`, `cyc` wraps to 0 and `rnd` increments.
  - When `rnd==NR` and `cyc==ROUND_LAT-1`: go to DONE.
- DONE:
  - `done_valid_o=1`, `en_o=0`, so the pipeline holds the ciphertext.
  - When `done_valid_o & done_ready_i`: go to IDLE.
- Output decode, from registers only (no combinational path from any input to any output):
  - `full_enc_o = RUN & (rnd==0)`
  - `zero_rnd_o = RUN & (rnd==0)`
  - `final_rnd_o = RUN & ((rnd==0) | (rnd==NR))`. Round 0 passes the plaintext; round NR skips mix-columns.
  - In IDLE and DONE, all three selects are 0.
  - `rnd_idx_o = rnd`, `busy_o = (state != IDLE)`.
- Round constant:
  - When `rnd` steps 0→1, `rcon` loads `8'h01`.
  - On each later increment, `rcon = xtime(rcon)`: shift left by 1; if the old bit 7 was set, XOR with `8'h1B`.
  - Sequence for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- `req_valid_i` outside IDLE is ignored. No queuing.
- `flush_i` has the highest priority after reset. In any state, the next cycle is IDLE with `rnd=0`, `cyc=0`, `rcon=0`, and no done is issued.
- Reset (asynchronous, mid-operation included) sets:
  - state IDLE, `rnd=0`, `cyc=0`, `rcon=0`
  - so `req_ready_o=1`, `done_valid_o=0`, `en_o=0`, all selects 0, `rnd_idx_o=0`, `rcon_o=0`, `busy_o=0`.

## Timing
- Cycle A is the rising edge where `req_valid_i & req_ready_o` is sampled high.
- RUN occupies cycles A+1 .. A+(NR+1)*ROUND_LAT. With defaults that is A+1..A+33.
- `done_valid_o` rises at A+(NR+1)*ROUND_LAT+1. With defaults that is A+34.
- `done_valid_o` and the ciphertext stay stable until the handshake cycle H. At H+1 the controller is in IDLE and `req_ready_o=1`.
- Minimum request-to-request period is (NR+1)*ROUND_LAT+2 cycles (35 with defaults).
- `req_ready_o` is low from A+1 until the cycle after the done handshake.
- Flush asserted in cycle F: at F+1 the state is IDLE. A request may be accepted at F+1.

## Test plan
- **Reset:** deassert `nrst` → all outputs at the listed reset values; `req_ready_o=1`.
- **Single run, defaults:** request at A, `done_ready_i=1`. Required response:
  - `en_o` high exactly cycles A+1..A+33.
  - selects `full_enc_o`/`zero_rnd_o`/`final_rnd_o`=1/1/1 in A+1..A+3, 0/0/0 in A+4..A+30, 0/0/1 in A+31..A+33.
  - `rcon_o` steps 00, 01, 02 … 1B, 36 every 3 cycles.
  - `done_valid_o` high at A+34 only.
  - Ciphertext matches FIPS-197 C.1 (key 000102…0f, plaintext 00112233…ff → 69c4e0d86a7b0430d8cdb78070b4c55a).
- **Backpressure:** `done_ready_i=0` for 5 cycles after done rises → `done_valid_o`, ciphertext and `en_o=0` are held; `req_valid_i` is ignored; IDLE follows one cycle after `done_ready_i` rises.
- **Flush:** assert `flush_i` at `rnd_idx_o=5` → next cycle IDLE, `rnd_idx_o=0`, `rcon_o=0`, no `done_valid_o`; a new request is accepted and completes correctly.
- **Async reset mid-run:** pulse `nrst` low at round 7 → outputs reach reset values immediately; the next request completes correctly.
- **Back-to-back, `ROUND_LAT=1`:** `req_valid_i` and `done_ready_i` held high → `done_valid_o` every 13 cycles; `rnd_idx_o` advances every cycle.

Source files
------------

// File: rtl/aes_enc_ctrl.sv
// Sequencing controller for an iterative AES-128 encryption datapath.
// Steps round 0 (key addition), the full rounds and the final round. It
// generates the pipeline enable, the round selects, the round index and the
// key-schedule round constant. The finished ciphertext is held until the
// consumer accepts it.
module aes_enc_ctrl #(
  parameter int unsigned NR        = 10,
  parameter int unsigned ROUND_LAT = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  output logic       done_valid_o,
  input  logic       done_ready_i,
  input  logic       flush_i,
  output logic       en_o,
  output logic       full_enc_o,
  output logic       zero_rnd_o,
  output logic       final_rnd_o,
  output logic [3:0] rnd_idx_o,
  output logic [7:0] rcon_o,
  output logic       busy_o
);

  localparam int unsigned RND_W  = 4;
  localparam int unsigned CYC_W  = 4;
  localparam int unsigned RCON_W = 8;

  localparam logic [RND_W-1:0]  RND_LAST  = RND_W'(NR);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(ROUND_LAT - 1);
  localparam logic [RCON_W-1:0] RCON_POLY = 8'h1B;
  localparam logic [RCON_W-1:0] RCON_R1   = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RND_W-1:0]    rnd_q, rnd_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [RCON_W-1:0]   rcon_q, rcon_d;
  logic                req_ready_d, done_valid_d, en_d, busy_d;
  logic                first_rnd_d, final_sel_d;

  // Next-state, counter/rcon update and next-cycle output decode
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    cyc_d   = cyc_q;
    rcon_d  = rcon_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = RUN;
          rnd_d   = '0;
          cyc_d   = '0;
          rcon_d  = '0;
        end
      end
      RUN: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (rnd_q == RND_LAST) begin
            state_d = DONE;
          end else begin
            rnd_d = rnd_q + RND_W'(1);
            // Round 1 seeds rcon; every later round applies xtime
            if (rnd_q == '0) begin
              rcon_d = RCON_R1;
            end else begin
              rcon_d = {rcon_q[RCON_W-2:0], 1'b0} ^ (rcon_q[RCON_W-1] ? RCON_POLY : '0);
            end
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      DONE: begin
        if (done_ready_i) begin
          state_d = IDLE;
          rnd_d   = '0;
          cyc_d   = '0;
          rcon_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        rnd_d   = '0;
        cyc_d   = '0;
        rcon_d  = '0;
      end
    endcase

    // Abort wins over every state transition and drops any pending done
    if (flush_i) begin
      state_d = IDLE;
      rnd_d   = '0;
      cyc_d   = '0;
      rcon_d  = '0;
    end

    req_ready_d  = (state_d == IDLE);
    done_valid_d = (state_d == DONE);
    en_d         = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    first_rnd_d  = (state_d == RUN) && (rnd_d == '0);
    final_sel_d  = (state_d == RUN) && ((rnd_d == '0) || (rnd_d == RND_LAST));
  end

  // State, counters and registered control outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      rnd_q        <= '0;
      cyc_q        <= '0;
      rcon_q       <= '0;
      req_ready_o  <= 1'b1;
      done_valid_o <= 1'b0;
      en_o         <= 1'b0;
      busy_o       <= 1'b0;
      full_enc_o   <= 1'b0;
      zero_rnd_o   <= 1'b0;
      final_rnd_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      cyc_q        <= cyc_d;
      rcon_q       <= rcon_d;
      req_ready_o  <= req_ready_d;
      done_valid_o <= done_valid_d;
      en_o         <= en_d;
      busy_o       <= busy_d;
      full_enc_o   <= first_rnd_d;
      zero_rnd_o   <= first_rnd_d;
      final_rnd_o  <= final_sel_d;
    end
  end

  assign rnd_idx_o = rnd_q;
  assign rcon_o    = rcon_q;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Directed bench for aes_enc_ctrl: default instance (NR=10, ROUND_LAT=3)
// plus a ROUND_LAT=1 instance for back-to-back operation.
module tb_aes_enc_ctrl;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // Default instance
  logic       req_valid0, req_ready0, done_valid0, done_ready0, flush0;
  logic       en0, full0, zero0, final0, busy0;
  logic [3:0] rnd0;
  logic [7:0] rcon0;

  // ROUND_LAT=1 instance
  logic       req_valid1, req_ready1, done_valid1, done_ready1, flush1;
  logic       en1, full1, zero1, final1, busy1;
  logic [3:0] rnd1;
  logic [7:0] rcon1;

  aes_enc_ctrl #(.NR(10), .ROUND_LAT(3)) dut0 (
    .clk(clk), .nrst(nrst),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0),
    .done_valid_o(done_valid0), .done_ready_i(done_ready0),
    .flush_i(flush0), .en_o(en0),
    .full_enc_o(full0), .zero_rnd_o(zero0), .final_rnd_o(final0),
    .rnd_idx_o(rnd0), .rcon_o(rcon0), .busy_o(busy0)
  );

  aes_enc_ctrl #(.NR(10), .ROUND_LAT(1)) dut1 (
    .clk(clk), .nrst(nrst),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .done_valid_o(done_valid1), .done_ready_i(done_ready1),
    .flush_i(flush1), .en_o(en1),
    .full_enc_o(full1), .zero_rnd_o(zero1), .final_rnd_o(final1),
    .rnd_idx_o(rnd1), .rcon_o(rcon1), .busy_o(busy1)
  );

  // Observation word: {ready, done, en, full, zero, final, busy, rnd[3:0], rcon[7:0]}
  logic [18:0] obs0, obs1;
  assign obs0 = {req_ready0, done_valid0, en0, full0, zero0, final0, busy0, rnd0, rcon0};
  assign obs1 = {req_ready1, done_valid1, en1, full1, zero1, final1, busy1, rnd1, rcon1};

  localparam logic [18:0] MASK_ALL  = 19'h7FFFF;
  localparam logic [18:0] MASK_CTRL = 19'h7F000;  // ignore rnd/rcon

  typedef struct {
    logic        req_valid;
    logic        done_ready;
    logic [18:0] exp;
    logic [18:0] mask;
  } vec_t;

  vec_t tbl[36];
  logic [7:0] rcon_tab[11];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [18:0] mk(input logic rdy, input logic dv, input logic en,
                                     input logic fe, input logic zr, input logic fr,
                                     input logic bz, input logic [3:0] r, input logic [7:0] c);
    return {rdy, dv, en, fe, zr, fr, bz, r, c};
  endfunction

  task automatic check_m(input string name, input logic [18:0] act,
                         input logic [18:0] exp, input logic [18:0] mask);
    n_tests++;
    if (((act ^ exp) & mask) !== 19'h0) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h (mask %05h) t=%0t", name, act, exp, mask, $time);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a request on dut0; returns in cycle A+1
  task automatic start0();
    req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
  endtask

  // From cycle A+1, count cycles until done_valid0 (bounded); returns offset from A
  task automatic run_to_done0(input string name, output int offs, output logic [7:0] last_rcon);
    offs = 1;
    last_rcon = 8'h00;
    while (!done_valid0 && offs < 60) begin
      if (en0) last_rcon = rcon0;
      tick();
      offs++;
    end
    check_i(name, offs, 34);
  endtask

  task automatic wait_rnd0(input string name, input logic [3:0] r);
    int n;
    n = 0;
    while (rnd0 != r && n < 60) begin
      tick();
      n++;
    end
    if (rnd0 != r) check_i(name, int'(rnd0), int'(r));
  endtask

  localparam logic [18:0] RST_VAL = 19'h40000;

  initial begin
    int offs;
    int r;
    logic [7:0] lr;
    int done_t[$];
    int cyc;
    logic prev_en;
    logic [3:0] prev_rnd;

    rcon_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // Row 0 is cycle A (request applied); rows 1..34 are A+1..A+34; row 35 is after handshake
    tbl[0] = '{1'b1, 1'b1, RST_VAL, MASK_ALL};
    for (int k = 1; k <= 33; k++) begin
      r = (k - 1) / 3;
      tbl[k] = '{1'b0, 1'b1,
                 mk(1'b0, 1'b0, 1'b1, r == 0, r == 0, (r == 0) || (r == 10), 1'b1,
                    4'(r), rcon_tab[r]),
                 MASK_ALL};
    end
    tbl[34] = '{1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 1, 4'h0, 8'h00), MASK_CTRL};
    tbl[35] = '{1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00), MASK_CTRL};

    nrst = 1'b0;
    req_valid0 = 0; done_ready0 = 0; flush0 = 0;
    req_valid1 = 0; done_ready1 = 0; flush1 = 0;

    // Reset values
    #12;
    check_m("reset0", obs0, RST_VAL, MASK_ALL);
    check_m("reset1", obs1, RST_VAL, MASK_ALL);
    @(negedge clk) nrst = 1'b1;
    tick();
    check_m("reset0_post", obs0, RST_VAL, MASK_ALL);

    // Single run, table driven
    for (int i = 0; i < 36; i++) begin
      req_valid0  = tbl[i].req_valid;
      done_ready0 = tbl[i].done_ready;
      check_m($sformatf("run_row%0d", i), obs0, tbl[i].exp, tbl[i].mask);
      tick();
    end
    req_valid0 = 1'b0;

    // Backpressure: done held 5 cycles with a stray request, then release
    done_ready0 = 1'b0;
    start0();
    run_to_done0("bp_latency", offs, lr);
    check_i("bp_last_rcon", int'(lr), 8'h36);
    req_valid0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_m($sformatf("bp_hold%0d", i), obs0, mk(0, 1, 0, 0, 0, 0, 1, 4'h0, 8'h00), MASK_CTRL);
      tick();
    end
    req_valid0  = 1'b0;
    done_ready0 = 1'b1;
    tick();
    check_m("bp_idle", obs0, mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00), MASK_CTRL);

    // Flush at round 5
    start0();
    wait_rnd0("flush_wait", 4'd5);
    check_m("flush_pre", obs0, mk(0, 0, 1, 0, 0, 0, 1, 4'd5, 8'h10), MASK_ALL);
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    check_m("flush_idle", obs0, RST_VAL, MASK_ALL);
    tick();
    check_m("flush_nodone", obs0, RST_VAL, MASK_ALL);
    start0();
    check_m("flush_rerun_r0", obs0, mk(0, 0, 1, 1, 1, 1, 1, 4'd0, 8'h00), MASK_ALL);
    run_to_done0("flush_rerun_latency", offs, lr);
    check_i("flush_rerun_rcon", int'(lr), 8'h36);
    tick();
    check_m("flush_rerun_idle", obs0, RST_VAL, MASK_CTRL);

    // Asynchronous reset at round 7
    start0();
    wait_rnd0("arst_wait", 4'd7);
    check_m("arst_pre", obs0, mk(0, 0, 1, 0, 0, 0, 1, 4'd7, 8'h40), MASK_ALL);
    #2 nrst = 1'b0;
    #1;
    check_m("arst_immediate", obs0, RST_VAL, MASK_ALL);
    @(negedge clk) nrst = 1'b1;
    tick();
    check_m("arst_held", obs0, RST_VAL, MASK_ALL);
    start0();
    run_to_done0("arst_rerun_latency", offs, lr);
    check_i("arst_rerun_rcon", int'(lr), 8'h36);
    tick();
    check_m("arst_rerun_idle", obs0, RST_VAL, MASK_CTRL);

    // Back-to-back with ROUND_LAT=1
    req_valid1  = 1'b1;
    done_ready1 = 1'b1;
    prev_en  = 1'b0;
    prev_rnd = 4'h0;
    for (cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (done_valid1) done_t.push_back(cyc);
      if (en1 && prev_en) check_i("b2b_rnd_step", int'(rnd1), int'(prev_rnd) + 1);
      prev_en  = en1;
      prev_rnd = rnd1;
    end
    req_valid1 = 1'b0;
    if (done_t.size() < 3) begin
      check_i("b2b_done_count", done_t.size(), 3);
    end else begin
      check_i("b2b_period0", done_t[1] - done_t[0], 13);
      check_i("b2b_period1", done_t[2] - done_t[1], 13);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
